// File: rtl/conv_buf_pkg.sv
// conv_buf_pkg: shared definitions for the convolution window buffer.
// Holds the derived-width helpers, the controller operation encoding and the
// element packing function used by the window generator, buffer and PE array.
package conv_buf_pkg;

  // One controller action per clock; flush dominates push/pop.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH,
    OP_FLUSH
  } buf_op_e;

  // Flattened window width: K*K*CHANNELS elements of DW bits.
  function automatic int unsigned calc_win_w(input int unsigned k,
                                             input int unsigned channels,
                                             input int unsigned dw);
    return k * k * channels * dw;
  endfunction

  // Occupancy count width able to hold 0..depth.
  function automatic int unsigned calc_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bit offset of element (r,c,ch) inside a flattened window.
  function automatic int unsigned elem_off(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned ch,
                                           input int unsigned k        = 3,
                                           input int unsigned channels = 1,
                                           input int unsigned dw       = 8);
    return ((r * k + c) * channels + ch) * dw;
  endfunction

endpackage

// File: rtl/conv_buf_ctrl.sv
// conv_buf_ctrl: pointer/count controller for the window FIFO.
// Ports:
//   clk, rst (async, active-low), flush (sync clear)
//   in_valid/in_ready   upstream handshake
//   out_valid/out_ready downstream handshake
//   count               windows held, 0..DEPTH
//   wr_en, wr_idx       slot write strobe and index
//   rd_idx              slot index of the head window
module conv_buf_ctrl
  import conv_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = calc_cnt_w(DEPTH),
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_idx,
  output logic [PTR_W-1:0] rd_idx
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  buf_op_e          w_op;
  logic             w_push;
  logic             w_pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready/valid decode from registered count only: no out_ready->in_ready path.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);

  always_comb begin
    w_op   = OP_IDLE;
    w_push = in_valid && in_ready;
    w_pop  = out_valid && out_ready;
    if (flush)               w_op = OP_FLUSH;
    else if (w_push && w_pop) w_op = OP_BOTH;
    else if (w_push)         w_op = OP_PUSH;
    else if (w_pop)          w_op = OP_POP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (w_op)
        OP_FLUSH: begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end
        OP_PUSH: begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
          r_count  <= r_count + 1'b1;
        end
        OP_POP: begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
          r_count  <= r_count - 1'b1;
        end
        OP_BOTH: begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        default: ;
      endcase
    end
  end

  // A flushed push is dropped, so the slot is never written for it.
  assign wr_en  = (w_op == OP_PUSH) || (w_op == OP_BOTH);
  assign wr_idx = r_wr_ptr;
  assign rd_idx = r_rd_ptr;
  assign count  = r_count;

endmodule

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: DEPTH-entry show-ahead FIFO of K x K x CHANNELS windows
// between the window generator and the convolution PE array.
// Ports:
//   clk, rst (async, active-low), flush (sync clear of queued windows)
//   in_valid/in_ready/in_data/in_last       upstream window stream
//   out_valid/out_ready/out_data/out_last   head window to the PE array
//   count                                   windows held, 0..DEPTH
// WIN_W and CNT_W are derived; leave them at their defaults.
module conv_window_buffer
  import conv_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K          = 3,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned WIN_W      = calc_win_w(K, CHANNELS, DATA_WIDTH),
  parameter int unsigned CNT_W      = calc_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIN_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIN_W-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIN_W-1:0] r_slot_data [DEPTH];
  logic [DEPTH-1:0] r_slot_last;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_rd_idx;

  conv_buf_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .wr_en     (w_wr_en),
    .wr_idx    (w_wr_idx),
    .rd_idx    (w_rd_idx)
  );

  // Flush leaves slot contents alone; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_slot_data[i] <= '0;
      r_slot_last <= '0;
    end else if (w_wr_en) begin
      r_slot_data[w_wr_idx] <= in_data;
      r_slot_last[w_wr_idx] <= in_last;
    end
  end

  // Show-ahead: head slot driven straight from the storage flops.
  assign out_data = r_slot_data[w_rd_idx];
  assign out_last = r_slot_last[w_rd_idx];

endmodule
